// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: 8259A rotating-priority resolver with a registered one-hot winner.
// Define PRIORITY_RESOLVER_SPECIAL_MASK_EN to add the special_mask_mode input.
module pic_priority_resolver (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] priority_rotate,
    input  logic [7:0] interrupt_mask,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] in_service_register,
`ifdef PRIORITY_RESOLVER_SPECIAL_MASK_EN
    input  logic       special_mask_mode,
`endif
    output logic [7:0] interrupt,
    output logic       interrupt_valid,
    output logic [2:0] interrupt_level
);
    function automatic logic [7:0] rot_r(input logic [7:0] x, input logic [2:0] s);
        for (int i = 0; i < 8; i++) rot_r[i] = x[3'(i) + s];
    endfunction
    function automatic logic [7:0] rot_l(input logic [7:0] x, input logic [2:0] s);
        for (int i = 0; i < 8; i++) rot_l[3'(i) + s] = x[i];
    endfunction
    logic [2:0] shift;
    logic [7:0] eff_isr;
    logic [7:0] req_rot;
    logic [7:0] isr_rot;
    logic [7:0] req_oh;
    logic [7:0] isr_oh;
    logic [7:0] win;
    logic [2:0] level;
`ifdef PRIORITY_RESOLVER_SPECIAL_MASK_EN
    assign eff_isr = special_mask_mode ? in_service_register & ~interrupt_mask : in_service_register;
`else
    assign eff_isr = in_service_register;
`endif
    // After rotation bit 0 is the highest priority, so one-hots compare numerically.
    always_comb begin
        shift   = priority_rotate + 3'd1;
        req_rot = rot_r(interrupt_request_register & ~interrupt_mask, shift);
        isr_rot = rot_r(eff_isr, shift);
        req_oh  = req_rot & (~req_rot + 8'd1);
        isr_oh  = isr_rot & (~isr_rot + 8'd1);
        win     = (req_oh != 8'd0 && (isr_oh == 8'd0 || req_oh < isr_oh)) ? rot_l(req_oh, shift) : 8'd0;
        level   = 3'd0;
        for (int i = 0; i < 8; i++) level = win[i] ? 3'(i) : level;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            interrupt       <= 8'd0;
            interrupt_valid <= 1'b0;
            interrupt_level <= 3'd0;
        end else begin
            interrupt       <= win;
            interrupt_valid <= |win;
            interrupt_level <= level;
        end
    end
endmodule

// File: tb/tb_pic_priority_resolver.sv
// tb_pic_priority_resolver: directed and random checks of the priority resolver against a level-walking model.
module tb_pic_priority_resolver;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] rot = 3'd7;
    logic [7:0] imr = 8'd0;
    logic [7:0] irr = 8'hFF;
    logic [7:0] isr = 8'd0;
    logic       smm = 1'b0;
    logic [7:0] interrupt;
    logic       interrupt_valid;
    logic [2:0] interrupt_level;
    int errors = 0;
    int checks = 0;
    pic_priority_resolver dut (
        .clk(clk),
        .reset_n(reset_n),
        .priority_rotate(rot),
        .interrupt_mask(imr),
        .interrupt_request_register(irr),
        .in_service_register(isr),
`ifdef PRIORITY_RESOLVER_SPECIAL_MASK_EN
        .special_mask_mode(smm),
`endif
        .interrupt(interrupt),
        .interrupt_valid(interrupt_valid),
        .interrupt_level(interrupt_level)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    // Walk levels from highest to lowest priority and take the first pending request and in-service level.
    task automatic model(input logic [2:0] r, input logic [7:0] m, input logic [7:0] q, input logic [7:0] s,
                         input logic sm, output logic [7:0] oh, output logic [2:0] lv);
        int rp = -1;
        int ip = -1;
        logic [7:0] es = sm ? (s & ~m) : s;
        for (int p = 0; p < 8; p++) begin
            int l = (int'(r) + 1 + p) % 8;
            if (rp < 0 && q[l] && !m[l]) rp = p;
            if (ip < 0 && es[l]) ip = p;
        end
        oh = 8'd0;
        lv = 3'd0;
        if (rp >= 0 && (ip < 0 || rp < ip)) begin
            lv = 3'((int'(r) + 1 + rp) % 8);
            oh = 8'd1 << lv;
        end
    endtask
    task automatic apply(input string tag, input logic [2:0] r, input logic [7:0] m, input logic [7:0] q,
                         input logic [7:0] s, input logic sm);
        logic [7:0] eoh;
        logic [2:0] elv;
        @(negedge clk);
        rot = r; imr = m; irr = q; isr = s; smm = sm;
        model(r, m, q, s, sm, eoh, elv);
        @(posedge clk);
        #1;
        check({tag, ".int"}, interrupt, eoh);
        check({tag, ".valid"}, {7'd0, interrupt_valid}, {7'd0, |eoh});
        check({tag, ".level"}, {5'd0, interrupt_level}, {5'd0, elv});
    endtask
    task automatic expect_int(input string tag, input logic [7:0] v);
        check(tag, interrupt, v);
    endtask
    initial begin
        #2;
        check("reset.int", interrupt, 8'd0);
        check("reset.valid", {7'd0, interrupt_valid}, 8'd0);
        check("reset.level", {5'd0, interrupt_level}, 8'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_release.int", interrupt, 8'd0);
        apply("idle", 3'b111, 8'd0, 8'd0, 8'd0, 1'b0);
        expect_int("idle.const", 8'd0);
        apply("rot_nested", 3'b001, 8'd0, 8'b00000011, 8'b00000010, 1'b0);
        expect_int("rot_nested.const", 8'b00000001);
        apply("blocked", 3'b111, 8'd0, 8'b00010000, 8'b00000100, 1'b0);
        expect_int("blocked.const", 8'd0);
        apply("unblocked", 3'b111, 8'd0, 8'b00010000, 8'd0, 1'b0);
        expect_int("unblocked.const", 8'b00010000);
        apply("masked_multi", 3'b111, 8'b00000111, 8'hFF, 8'd0, 1'b0);
        expect_int("masked_multi.const", 8'b00001000);
        apply("rot4_multi", 3'b100, 8'd0, 8'hFF, 8'd0, 1'b0);
        expect_int("rot4_multi.const", 8'b00100000);
        apply("same_level", 3'b111, 8'd0, 8'b00000100, 8'b00000100, 1'b0);
        expect_int("same_level.const", 8'd0);
        apply("all_masked", 3'b010, 8'hFF, 8'hFF, 8'd0, 1'b0);
        apply("level7", 3'b110, 8'd0, 8'b10000000, 8'd0, 1'b0);
`ifdef PRIORITY_RESOLVER_SPECIAL_MASK_EN
        apply("smm_on", 3'b111, 8'b00000001, 8'b01000000, 8'b00000001, 1'b1);
        expect_int("smm_on.const", 8'b01000000);
        apply("smm_off", 3'b111, 8'b00000001, 8'b01000000, 8'b00000001, 1'b0);
        expect_int("smm_off.const", 8'd0);
`endif
        for (int n = 0; n < 400; n++) begin
            logic [7:0] q = 8'($urandom);
            logic [7:0] m = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom) & 8'($urandom);
            logic [7:0] s = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'd1 << $urandom_range(0, 7);
            logic sm = 1'b0;
`ifdef PRIORITY_RESOLVER_SPECIAL_MASK_EN
            sm = 1'($urandom);
`endif
            if ($urandom_range(0, 3) == 0) s = s | 8'($urandom);
            apply("random", 3'($urandom), m, q, s, sm);
        end
        apply("pre_reset", 3'b111, 8'd0, 8'hFF, 8'd0, 1'b0);
        expect_int("pre_reset.const", 8'b00000001);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset.int", interrupt, 8'd0);
        check("async_reset.valid", {7'd0, interrupt_valid}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        apply("after_reset", 3'b011, 8'd0, 8'hFF, 8'd0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
